// File: rtl/axis_reduce_pkg.sv
// Shared types and elaboration-time helpers for the AXI4-Stream group reducer.
package axis_reduce_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    // Ceiling log2, never below 1 so every pointer has at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Number of result registers: ceil(max_in / grp); guarded against grp == 0.
    function automatic int unsigned out_depth(input int unsigned max_in, input int unsigned grp);
        return (grp == 0) ? max_in : (max_in + grp - 1) / grp;
    endfunction

    function automatic bit params_legal(input int unsigned width, input int unsigned grp,
                                        input int unsigned max_in);
        return (grp >= 1) && (max_in >= grp) && (width >= 8) && ((width % 8) == 0);
    endfunction

endpackage

// File: rtl/axis_reduce_acc.sv
// Group accumulator: sums consecutive beats, tracks position within the group
// and flags the beat that closes a group.
// Build option: AXIS_REDUCE_SAT_EN selects unsigned saturating addition
// instead of modulo-2^W wrap-around.
module axis_reduce_acc
    import axis_reduce_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned GROUP_SIZE       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        beat,
    input  logic                        frame_end_in,
    input  logic [AXIS_TDATA_WIDTH-1:0] din,
    output logic [AXIS_TDATA_WIDTH-1:0] acc_next,
    output logic                        close_grp
);

    localparam int unsigned GW = clog2_min1(GROUP_SIZE);

    logic [AXIS_TDATA_WIDTH-1:0] acc_q,     acc_d;
    logic [GW-1:0]               grp_cnt_q, grp_cnt_d;
    logic [AXIS_TDATA_WIDTH-1:0] add_res;

`ifdef AXIS_REDUCE_SAT_EN
    logic [AXIS_TDATA_WIDTH:0] sum_ext;

    // Saturating add: a carry-out pins the result at all ones; an already
    // saturated accumulator stays saturated for the rest of the group.
    always_comb begin
        sum_ext = {1'b0, acc_q} + {1'b0, din};
        add_res = sum_ext[AXIS_TDATA_WIDTH] ? '1 : sum_ext[AXIS_TDATA_WIDTH-1:0];
    end
`else
    // Wrap-around add modulo 2^W.
    always_comb begin
        add_res = acc_q + din;
    end
`endif

    // First beat of a group loads, later beats accumulate; close on full group or frame end.
    always_comb begin
        acc_next  = (grp_cnt_q == '0) ? din : add_res;
        close_grp = (grp_cnt_q == GW'(GROUP_SIZE - 1)) || frame_end_in;
    end

    // Next-state for the running sum and group counter.
    always_comb begin
        acc_d     = acc_q;
        grp_cnt_d = grp_cnt_q;
        if (beat) begin
            if (close_grp) begin
                acc_d     = '0;
                grp_cnt_d = '0;
            end else begin
                acc_d     = acc_next;
                grp_cnt_d = grp_cnt_q + 1'b1;
            end
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            grp_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            grp_cnt_q <= grp_cnt_d;
        end
    end

endmodule

// File: rtl/axis_group_reducer.sv
// AXI4-Stream store-and-forward reducer: each group of GROUP_SIZE input beats
// is summed into one result word; the reduced frame is then replayed on the
// master port with TLAST on its final word. Single buffer, no frame overlap.
// Build option: AXIS_REDUCE_SAT_EN (saturating instead of wrapping sums).
module axis_group_reducer
    import axis_reduce_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned GROUP_SIZE       = 2,
    parameter int unsigned MAX_IN_WORDS     = 8
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESET,
    input  logic                          S_AXIS_TVALID,
    output logic                          S_AXIS_TREADY,
    input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                          S_AXIS_TLAST,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic [AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                          M_AXIS_TLAST,
    output logic [AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                          FRAME_TRUNC,
    output logic                          BUSY
);

    localparam int unsigned OUT_DEPTH = out_depth(MAX_IN_WORDS, GROUP_SIZE);
    localparam int unsigned IW        = clog2_min1(MAX_IN_WORDS);
    localparam int unsigned PW        = clog2_min1(OUT_DEPTH);
    localparam int unsigned NW        = clog2_min1(OUT_DEPTH + 1);

    if (!params_legal(AXIS_TDATA_WIDTH, GROUP_SIZE, MAX_IN_WORDS)) begin : g_param_check
        $error("axis_group_reducer: illegal GROUP_SIZE / MAX_IN_WORDS / AXIS_TDATA_WIDTH");
    end

    state_t                      state_q, state_d;
    logic [IW-1:0]               in_cnt_q, in_cnt_d;
    logic [PW-1:0]               wptr_q, wptr_d;
    logic [PW-1:0]               rptr_q, rptr_d;
    logic [NW-1:0]               nout_q, nout_d;
    logic                        frame_trunc_q, frame_trunc_d;
    logic [AXIS_TDATA_WIDTH-1:0] mem_q [OUT_DEPTH];

    logic                        s_ready;
    logic                        m_valid;
    logic                        busy;
    logic                        beat;
    logic                        frame_end_in;
    logic                        frame_end;
    logic                        m_hs;
    logic                        rd_last;
    logic [AXIS_TDATA_WIDTH-1:0] acc_next;
    logic                        close_grp;

    axis_reduce_acc #(
        .AXIS_TDATA_WIDTH (AXIS_TDATA_WIDTH),
        .GROUP_SIZE       (GROUP_SIZE)
    ) u_acc (
        .clk          (AXIS_ACLK),
        .rst          (AXIS_ARESET),
        .beat         (beat),
        .frame_end_in (frame_end_in),
        .din          (S_AXIS_TDATA),
        .acc_next     (acc_next),
        .close_grp    (close_grp)
    );

    // Handshake and frame-boundary decode shared by FSM and datapath.
    always_comb begin
        beat         = S_AXIS_TVALID && s_ready;
        frame_end_in = S_AXIS_TLAST || (in_cnt_q == IW'(MAX_IN_WORDS - 1));
        frame_end    = beat && frame_end_in;
        m_hs         = m_valid && M_AXIS_TREADY;
        rd_last      = (NW'(rptr_q) == (nout_q - NW'(1)));
    end

    // FSM state register.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: collect until frame end, drain until the TLAST handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (frame_end)       state_d = DRAIN;
            DRAIN:   if (m_hs && rd_last) state_d = COLLECT;
            default:                      state_d = COLLECT;
        endcase
    end

    // FSM outputs: strictly one port direction active at a time.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            COLLECT: s_ready = 1'b1;
            DRAIN: begin
                m_valid = 1'b1;
                busy    = 1'b1;
            end
            default: s_ready = 1'b0;
        endcase
    end

    // Counter and pointer next-state; write pointer advances once per closed group.
    always_comb begin
        in_cnt_d      = in_cnt_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        nout_d        = nout_q;
        frame_trunc_d = 1'b0;
        if (beat) begin
            in_cnt_d = in_cnt_q + 1'b1;
            if (close_grp) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (frame_end_in) begin
                nout_d        = NW'(wptr_q) + NW'(1);
                in_cnt_d      = '0;
                frame_trunc_d = !S_AXIS_TLAST;
            end
        end
        if (m_hs) begin
            rptr_d = rptr_q + 1'b1;
            if (rd_last) begin
                rptr_d = '0;
                wptr_d = '0;
            end
        end
    end

    // Control registers.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            in_cnt_q      <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            nout_q        <= '0;
            frame_trunc_q <= 1'b0;
        end else begin
            in_cnt_q      <= in_cnt_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            nout_q        <= nout_d;
            frame_trunc_q <= frame_trunc_d;
        end
    end

    // Result memory: written only while collecting, so read data is stable during drain.
    always_ff @(posedge AXIS_ACLK) begin
        if (beat && close_grp) begin
            mem_q[wptr_q] <= acc_next;
        end
    end

    // Master-side outputs.
    always_comb begin
        S_AXIS_TREADY = s_ready;
        M_AXIS_TVALID = m_valid;
        M_AXIS_TDATA  = mem_q[rptr_q];
        M_AXIS_TLAST  = m_valid && rd_last;
        M_AXIS_TKEEP  = '1;
        FRAME_TRUNC   = frame_trunc_q;
        BUSY          = busy;
    end

endmodule

// File: tb/tb_axis_group_reducer.sv
// Directed bench for axis_group_reducer: a default instance (GROUP_SIZE=2,
// MAX_IN_WORDS=8) driven from a vector table plus hand sequences, and a
// GROUP_SIZE=4 / MAX_IN_WORDS=12 instance.
`timescale 1ns/1ps
module tb_axis_group_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        frame_trunc, busy;

    logic        s2_tvalid, s2_tready, s2_tlast;
    logic [31:0] s2_tdata;
    logic        m2_tvalid, m2_tready, m2_tlast;
    logic [31:0] m2_tdata;
    logic [3:0]  m2_tkeep;
    logic        frame_trunc2, busy2;

    axis_group_reducer #(.AXIS_TDATA_WIDTH(32), .GROUP_SIZE(2), .MAX_IN_WORDS(8)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TLAST(s_tlast),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast), .M_AXIS_TKEEP(m_tkeep),
        .FRAME_TRUNC(frame_trunc), .BUSY(busy)
    );

    axis_group_reducer #(.AXIS_TDATA_WIDTH(32), .GROUP_SIZE(4), .MAX_IN_WORDS(12)) dut2 (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S_AXIS_TVALID(s2_tvalid), .S_AXIS_TREADY(s2_tready),
        .S_AXIS_TDATA(s2_tdata), .S_AXIS_TLAST(s2_tlast),
        .M_AXIS_TVALID(m2_tvalid), .M_AXIS_TREADY(m2_tready),
        .M_AXIS_TDATA(m2_tdata), .M_AXIS_TLAST(m2_tlast), .M_AXIS_TKEEP(m2_tkeep),
        .FRAME_TRUNC(frame_trunc2), .BUSY(busy2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output collectors: sample mid-low-phase, record every handshake.
    logic [32:0] q1[$];
    logic [32:0] q2[$];
    int          trunc1 = 0;
    int          trunc2 = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(m_tvalid), 64'd1);
                check("stall_data",  64'(m_tdata),  64'(prev_data));
                check("stall_last",  64'(m_tlast),  64'(prev_last));
            end
            if (m_tvalid) check("s_ready_in_drain", 64'(s_tready), 64'd0);
            if (frame_trunc) trunc1++;
            if (m_tvalid && m_tready) q1.push_back({m_tlast, m_tdata});
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (frame_trunc2) trunc2++;
            if (m2_tvalid && m2_tready) q2.push_back({m2_tlast, m2_tdata});
        end
    end

    // Tasks start and end right after a falling edge.
    task automatic send1(input logic [31:0] d, input logic l);
        bit hs;
        bit done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        for (int i = 0; i < 200; i++) begin
            hs = s_tready;
            @(negedge clk);
            if (hs) begin
                done = 1'b1;
                break;
            end
        end
        check("send1_accept", 64'(done), 64'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send2(input logic [31:0] d, input logic l);
        bit hs;
        bit done;
        done      = 1'b0;
        s2_tvalid = 1'b1;
        s2_tdata  = d;
        s2_tlast  = l;
        for (int i = 0; i < 200; i++) begin
            hs = s2_tready;
            @(negedge clk);
            if (hs) begin
                done = 1'b1;
                break;
            end
        end
        check("send2_accept", 64'(done), 64'd1);
        s2_tvalid = 1'b0;
        s2_tlast  = 1'b0;
    endtask

    task automatic drain1(input int unsigned n_exp, input bit toggle);
        m_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #3;
            if (q1.size() >= n_exp) break;
            @(negedge clk);
            if (toggle) m_tready = ~m_tready;
        end
        @(negedge clk);
        m_tready = 1'b0;
    endtask

    typedef struct {
        int unsigned n_in;
        logic [31:0] din[8];
        bit          last;
        bit          toggle;
        int unsigned n_out;
        logic [31:0] dout[4];
        int unsigned trunc;
    } vec_t;

    localparam int NV = 7;
    vec_t vec[NV];

    task automatic run_vec(input int idx, input vec_t v);
        for (int unsigned b = 0; b < v.n_in; b++)
            send1(v.din[b], v.last && (b == v.n_in - 1));
        check($sformatf("v%0d_latency_valid", idx), 64'(m_tvalid), 64'd1);
        check($sformatf("v%0d_latency_busy", idx),  64'(busy),     64'd1);
        drain1(v.n_out, v.toggle);
        check($sformatf("v%0d_out_count", idx), 64'(q1.size()), 64'(v.n_out));
        for (int unsigned k = 0; k < v.n_out; k++) begin
            if (k < q1.size()) begin
                check($sformatf("v%0d_data%0d", idx, k), 64'(q1[k][31:0]), 64'(v.dout[k]));
                check($sformatf("v%0d_last%0d", idx, k), 64'(q1[k][32]), 64'(k == v.n_out - 1));
            end
        end
        check($sformatf("v%0d_trunc", idx),   64'(trunc1),   64'(v.trunc));
        check($sformatf("v%0d_s_ready", idx), 64'(s_tready), 64'd1);
        check($sformatf("v%0d_m_valid", idx), 64'(m_tvalid), 64'd0);
        q1.delete();
        trunc1 = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        s_tvalid  = 1'b0; s_tdata  = '0; s_tlast  = 1'b0; m_tready  = 1'b0;
        s2_tvalid = 1'b0; s2_tdata = '0; s2_tlast = 1'b0; m2_tready = 1'b1;

        vec[0].n_in = 8; vec[0].din = '{1, 2, 3, 4, 5, 6, 7, 8}; vec[0].last = 1; vec[0].toggle = 0;
        vec[0].n_out = 4; vec[0].dout = '{3, 7, 11, 15}; vec[0].trunc = 0;
        vec[1].n_in = 5; vec[1].din = '{1, 2, 3, 4, 5, 0, 0, 0}; vec[1].last = 1; vec[1].toggle = 0;
        vec[1].n_out = 3; vec[1].dout = '{3, 7, 5, 0}; vec[1].trunc = 0;
        vec[2].n_in = 1; vec[2].din = '{9, 0, 0, 0, 0, 0, 0, 0}; vec[2].last = 1; vec[2].toggle = 0;
        vec[2].n_out = 1; vec[2].dout = '{9, 0, 0, 0}; vec[2].trunc = 0;
        vec[3].n_in = 2; vec[3].din = '{32'hFFFF_FFFF, 2, 0, 0, 0, 0, 0, 0}; vec[3].last = 1; vec[3].toggle = 0;
        vec[3].n_out = 1; vec[3].trunc = 0;
        vec[4].n_in = 3; vec[4].din = '{32'hFFFF_FFFF, 1, 5, 0, 0, 0, 0, 0}; vec[4].last = 1; vec[4].toggle = 0;
        vec[4].n_out = 2; vec[4].trunc = 0;
`ifdef AXIS_REDUCE_SAT_EN
        vec[3].dout = '{32'hFFFF_FFFF, 0, 0, 0};
        vec[4].dout = '{32'hFFFF_FFFF, 5, 0, 0};
`else
        vec[3].dout = '{32'h0000_0001, 0, 0, 0};
        vec[4].dout = '{32'h0000_0000, 5, 0, 0};
`endif
        vec[5].n_in = 8; vec[5].din = '{1, 1, 1, 1, 1, 1, 1, 1}; vec[5].last = 0; vec[5].toggle = 0;
        vec[5].n_out = 4; vec[5].dout = '{2, 2, 2, 2}; vec[5].trunc = 1;
        vec[6].n_in = 8; vec[6].din = '{1, 2, 3, 4, 5, 6, 7, 8}; vec[6].last = 1; vec[6].toggle = 1;
        vec[6].n_out = 4; vec[6].dout = '{3, 7, 11, 15}; vec[6].trunc = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", 64'(m_tvalid),    64'd0);
        check("rst_m_last",  64'(m_tlast),     64'd0);
        check("rst_trunc",   64'(frame_trunc), 64'd0);
        check("rst_busy",    64'(busy),        64'd0);
        check("rst_s_ready", 64'(s_tready),    64'd1);
        check("tkeep",       64'(m_tkeep),     64'hF);
        rst = 1'b0;
        @(negedge clk);
        check("idle_m_valid", 64'(m_tvalid), 64'd0);

        for (int i = 0; i < NV; i++) run_vec(i, vec[i]);

        // Ten unterminated beats: first eight truncate, the rest start the next frame.
        m_tready = 1'b1;
        for (int i = 0; i < 10; i++) send1(32'd1, 1'b0);
        send1(32'd1, 1'b1);
        drain1(6, 0);
        check("trunc10_count", 64'(q1.size()), 64'd6);
        if (q1.size() == 6) begin
            check("trunc10_w0", 64'(q1[0]), 64'({1'b0, 32'd2}));
            check("trunc10_w1", 64'(q1[1]), 64'({1'b0, 32'd2}));
            check("trunc10_w2", 64'(q1[2]), 64'({1'b0, 32'd2}));
            check("trunc10_w3", 64'(q1[3]), 64'({1'b1, 32'd2}));
            check("trunc10_w4", 64'(q1[4]), 64'({1'b0, 32'd2}));
            check("trunc10_w5", 64'(q1[5]), 64'({1'b1, 32'd1}));
        end
        check("trunc10_pulses", 64'(trunc1), 64'd1);
        q1.delete();
        trunc1 = 0;

        // Reset in the middle of a drain, after two words have left.
        for (int i = 1; i <= 8; i++) send1(32'(i), i == 8);
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_m_valid", 64'(m_tvalid), 64'd0);
        check("mid_rst_busy",    64'(busy),     64'd0);
        check("mid_rst_m_last",  64'(m_tlast),  64'd0);
        check("mid_rst_s_ready", 64'(s_tready), 64'd1);
        check("mid_rst_sent",    64'(q1.size()), 64'd2);
        @(negedge clk);
        rst      = 1'b0;
        m_tready = 1'b0;
        @(negedge clk);
        check("post_rst_m_valid", 64'(m_tvalid), 64'd0);
        q1.delete();
        trunc1 = 0;
        send1(32'd4, 1'b0);
        send1(32'd4, 1'b1);
        drain1(1, 0);
        check("post_rst_count", 64'(q1.size()), 64'd1);
        if (q1.size() >= 1) check("post_rst_word", 64'(q1[0]), 64'({1'b1, 32'd8}));
        q1.delete();

        // GROUP_SIZE=4, MAX_IN_WORDS=12 instance.
        for (int i = 1; i <= 12; i++) send2(32'(i), 1'b0);
        for (int i = 1; i <= 5; i++) send2(32'(i), i == 5);
        for (int i = 0; i < 100; i++) begin
            #3;
            if (q2.size() >= 5) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("g4_count", 64'(q2.size()), 64'd5);
        if (q2.size() == 5) begin
            check("g4_w0", 64'(q2[0]), 64'({1'b0, 32'd10}));
            check("g4_w1", 64'(q2[1]), 64'({1'b0, 32'd26}));
            check("g4_w2", 64'(q2[2]), 64'({1'b1, 32'd42}));
            check("g4_w3", 64'(q2[3]), 64'({1'b0, 32'd10}));
            check("g4_w4", 64'(q2[4]), 64'({1'b1, 32'd5}));
        end
        check("g4_trunc",   64'(trunc2),    64'd1);
        check("g4_tkeep",   64'(m2_tkeep),  64'hF);
        check("g4_s_ready", 64'(s2_tready), 64'd1);
        check("g4_busy",    64'(busy2),     64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
